// File: rtl/kairo_opfetch.sv
// kairo_opfetch: operand-fetch stage between decode and execute.
// Hides the regfile read latency, bypasses writeback, interlocks debug AR.
module kairo_opfetch #(
    parameter int XLEN  = 32,
    parameter int TASKW = 1,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [TASKW-1:0] id_task_i,
    input  logic [AW-1:0]    id_rs1_i,
    input  logic [AW-1:0]    id_rs2_i,
    input  logic [AW-1:0]    id_rd_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_insn_i,
    output logic [TASKW-1:0] rtasknum_o,
    output logic [AW-1:0]    rs1addr_o,
    output logic [AW-1:0]    rs2addr_o,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic             wb_we_i,
    input  logic [TASKW-1:0] wb_task_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             ar_en_i,
    input  logic             flush_i,
    input  logic [TASKW-1:0] flush_task_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [TASKW-1:0] ex_task_o,
    output logic [AW-1:0]    ex_rd_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_insn_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o
);

    logic             s1_valid_q, s1_valid_d;
    logic [TASKW-1:0] s1_task_q, s1_task_d;
    logic [AW-1:0]    s1_rs1_q, s1_rs1_d;
    logic [AW-1:0]    s1_rs2_q, s1_rs2_d;
    logic [AW-1:0]    s1_rd_q, s1_rd_d;
    logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
    logic [XLEN-1:0]  s1_insn_q, s1_insn_d;

    logic             ar_d_q;
    logic             db1_q, db1_d;
    logic             db2_q, db2_d;
    logic [XLEN-1:0]  dbdat_q;

    logic             ex_valid_q, ex_valid_d;
    logic [TASKW-1:0] ex_task_q, ex_task_d;
    logic [AW-1:0]    ex_rd_q, ex_rd_d;
    logic [AW-1:0]    ex_rs1a_q, ex_rs1a_d;
    logic [AW-1:0]    ex_rs2a_q, ex_rs2a_d;
    logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]  ex_insn_q, ex_insn_d;
    logic [XLEN-1:0]  ex_op1_q, ex_op1_d;
    logic [XLEN-1:0]  ex_op2_q, ex_op2_d;

    logic            wb_ok, s2_load, s1_adv, s1_go;
    logic            s1_kill, ex_kill, id_fire, id_take, ex_stall;
    logic            wb_s1, wb_ex;
    logic [XLEN-1:0] op1, op2;

    function automatic logic [XLEN-1:0] pick(
        input logic [AW-1:0]   src,
        input logic            wb_hit,
        input logic            db_hit,
        input logic [XLEN-1:0] wbd,
        input logic [XLEN-1:0] dbd,
        input logic [XLEN-1:0] rf
    );
        if (src == '0)  return '0;
        if (wb_hit)     return wbd;
        if (db_hit)     return dbd;
        return rf;
    endfunction

    always_comb begin
        wb_ok      = wb_we_i & (wb_addr_i != '0);
        s2_load    = !ex_valid_q | ex_ready_i;
        s1_adv     = s1_valid_q & !ar_d_q & s2_load;
        s1_kill    = flush_i & (s1_task_q == flush_task_i);
        ex_kill    = flush_i & (ex_task_q == flush_task_i);
        s1_go      = s1_adv & !s1_kill;
        id_ready_o = !ar_en_i & (!s1_valid_q | s1_adv);
        id_fire    = id_valid_i & id_ready_o;
        id_take    = id_fire & !(flush_i & (id_task_i == flush_task_i));
        ex_stall   = ex_valid_q & !ex_ready_i;
        // Re-read the held entry whenever decode is not handing over a new one
        rtasknum_o = id_fire ? id_task_i : s1_task_q;
        rs1addr_o  = id_fire ? id_rs1_i : s1_rs1_q;
        rs2addr_o  = id_fire ? id_rs2_i : s1_rs2_q;
        // A write on the read edge is missed by the RAM, so remember it
        db1_d = wb_ok & (wb_task_i == rtasknum_o) & (wb_addr_i == rs1addr_o);
        db2_d = wb_ok & (wb_task_i == rtasknum_o) & (wb_addr_i == rs2addr_o);
        wb_s1 = wb_ok & (wb_task_i == s1_task_q);
        wb_ex = ex_stall & wb_ok & (wb_task_i == ex_task_q);
        op1 = pick(s1_rs1_q, wb_s1 & (wb_addr_i == s1_rs1_q),
                   db1_q, wb_data_i, dbdat_q, rs1_i);
        op2 = pick(s1_rs2_q, wb_s1 & (wb_addr_i == s1_rs2_q),
                   db2_q, wb_data_i, dbdat_q, rs2_i);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_task_d  = s1_task_q;
        s1_rs1_d   = s1_rs1_q;
        s1_rs2_d   = s1_rs2_q;
        s1_rd_d    = s1_rd_q;
        s1_pc_d    = s1_pc_q;
        s1_insn_d  = s1_insn_q;
        ex_valid_d = ex_valid_q;
        ex_task_d  = ex_task_q;
        ex_rd_d    = ex_rd_q;
        ex_rs1a_d  = ex_rs1a_q;
        ex_rs2a_d  = ex_rs2a_q;
        ex_pc_d    = ex_pc_q;
        ex_insn_d  = ex_insn_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;

        if (id_take) begin
            s1_valid_d = 1'b1;
            s1_task_d  = id_task_i;
            s1_rs1_d   = id_rs1_i;
            s1_rs2_d   = id_rs2_i;
            s1_rd_d    = id_rd_i;
            s1_pc_d    = id_pc_i;
            s1_insn_d  = id_insn_i;
        end else if (s1_go | s1_kill) begin
            s1_valid_d = 1'b0;
        end

        if (s1_go) begin
            ex_valid_d = 1'b1;
            ex_task_d  = s1_task_q;
            ex_rd_d    = s1_rd_q;
            ex_rs1a_d  = s1_rs1_q;
            ex_rs2a_d  = s1_rs2_q;
            ex_pc_d    = s1_pc_q;
            ex_insn_d  = s1_insn_q;
            ex_op1_d   = op1;
            ex_op2_d   = op2;
        end else begin
            if (ex_ready_i | ex_kill) ex_valid_d = 1'b0;
            if (wb_ex && wb_addr_i == ex_rs1a_q) ex_op1_d = wb_data_i;
            if (wb_ex && wb_addr_i == ex_rs2a_q) ex_op2_d = wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_task_q  <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_rd_q    <= '0;
            s1_pc_q    <= '0;
            s1_insn_q  <= '0;
            ar_d_q     <= 1'b1;
            db1_q      <= 1'b0;
            db2_q      <= 1'b0;
            dbdat_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_task_q  <= '0;
            ex_rd_q    <= '0;
            ex_rs1a_q  <= '0;
            ex_rs2a_q  <= '0;
            ex_pc_q    <= '0;
            ex_insn_q  <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_task_q  <= s1_task_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s1_rd_q    <= s1_rd_d;
            s1_pc_q    <= s1_pc_d;
            s1_insn_q  <= s1_insn_d;
            ar_d_q     <= ar_en_i;
            db1_q      <= db1_d;
            db2_q      <= db2_d;
            dbdat_q    <= wb_data_i;
            ex_valid_q <= ex_valid_d;
            ex_task_q  <= ex_task_d;
            ex_rd_q    <= ex_rd_d;
            ex_rs1a_q  <= ex_rs1a_d;
            ex_rs2a_q  <= ex_rs2a_d;
            ex_pc_q    <= ex_pc_d;
            ex_insn_q  <= ex_insn_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_task_o     = ex_task_q;
    assign ex_rd_o       = ex_rd_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_insn_o     = ex_insn_q;
    assign ex_rs1_data_o = ex_op1_q;
    assign ex_rs2_data_o = ex_op2_q;

endmodule

// File: tb/tb_kairo_opfetch.sv
// tb_kairo_opfetch: random and directed stimulus against a transaction model.
// The regfile is modelled here; expected operands come from architectural state.
module tb_kairo_opfetch;

    typedef struct {
        logic        tsk;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] insn;
        int          fire;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic        id_task;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_pc, id_insn;
    logic        rtask;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rf_rs1, rf_rs2;
    logic        wb_we, wb_task;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ar_en, flush, flush_task;
    logic        ex_valid, ex_ready, ex_task;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, ex_insn, ex_d1, ex_d2;

    logic [31:0] regs [2][32];
    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          beats = 0;
    bit          exact_lat = 0;

    kairo_opfetch dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_task_i(id_task), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rd_i(id_rd), .id_pc_i(id_pc), .id_insn_i(id_insn),
        .rtasknum_o(rtask), .rs1addr_o(rs1a), .rs2addr_o(rs2a),
        .rs1_i(rf_rs1), .rs2_i(rf_rs2),
        .wb_we_i(wb_we), .wb_task_i(wb_task),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .ar_en_i(ar_en), .flush_i(flush), .flush_task_i(flush_task),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_task_o(ex_task), .ex_rd_o(ex_rd),
        .ex_pc_o(ex_pc), .ex_insn_o(ex_insn),
        .ex_rs1_data_o(ex_d1), .ex_rs2_data_o(ex_d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read regfile; debug access steals the RS1 port
    always @(posedge clk) begin
        rf_rs1 <= ar_en ? {16'hDEAD, 16'($urandom)} : regs[rtask][rs1a];
        rf_rs2 <= regs[rtask][rs2a];
        if (wb_we && wb_addr != 5'd0) regs[wb_task][wb_addr] <= wb_data;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] arch(input logic t, input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[t][r];
    endfunction

    task automatic monitor();
        ent_t e;
        ent_t keep[$];
        cyc++;
        if (ar_en) check("id_ready_ar", 64'(id_ready), 64'd0);
        if (ex_valid && ex_ready && !(flush && ex_task == flush_task)) begin
            if (q.size() == 0) begin
                check("ex_spurious", 64'(ex_valid), 64'd0);
            end else begin
                e = q.pop_front();
                beats++;
                check("ex_task", 64'(ex_task), 64'(e.tsk));
                check("ex_rd", 64'(ex_rd), 64'(e.rd));
                check("ex_pc", 64'(ex_pc), 64'(e.pc));
                check("ex_insn", 64'(ex_insn), 64'(e.insn));
                check("ex_rs1", 64'(ex_d1), 64'(arch(e.tsk, e.rs1)));
                check("ex_rs2", 64'(ex_d2), 64'(arch(e.tsk, e.rs2)));
                check("lat_min", 64'((cyc - e.fire) >= 2), 64'd1);
                if (exact_lat) check("lat_b2b", 64'(cyc - e.fire), 64'd2);
            end
        end
        if (flush) begin
            foreach (q[i]) if (q[i].tsk != flush_task) keep.push_back(q[i]);
            q = keep;
        end
        if (id_valid && id_ready && !(flush && id_task == flush_task)) begin
            e = '{id_task, id_rs1, id_rs2, id_rd, id_pc, id_insn, cyc};
            q.push_back(e);
        end
        check("inflight", 64'(q.size() <= 2), 64'd1);
    endtask

    task automatic idle();
        id_valid = 0; wb_we = 0; ar_en = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic tick();
        #1;
        if (rst_n) monitor();
        @(negedge clk);
    endtask

    task automatic offer(input logic t, input logic [4:0] r1,
                         input logic [4:0] r2);
        id_valid = 1; id_task = t; id_rs1 = r1; id_rs2 = r2;
        id_rd = 5'($urandom); id_pc = $urandom; id_insn = $urandom;
    endtask

    task automatic wb(input logic t, input logic [4:0] a,
                      input logic [31:0] d);
        wb_we = 1; wb_task = t; wb_addr = a; wb_data = d;
    endtask

    initial begin
        int b0;
        int arc;
        idle();
        id_task = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_pc = 0; id_insn = 0; wb_task = 0; wb_addr = 0;
        wb_data = 0; flush_task = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_exv", 64'(ex_valid), 64'd0);
        check("rst_task", 64'(ex_task), 64'd0);
        check("rst_rd", 64'(ex_rd), 64'd0);
        check("rst_pc", 64'(ex_pc), 64'd0);
        check("rst_insn", 64'(ex_insn), 64'd0);
        check("rst_d1", 64'(ex_d1), 64'd0);
        check("rst_d2", 64'(ex_d2), 64'd0);
        rst_n = 1;
        #1 check("rst_idrdy", 64'(id_ready), 64'd1);
        @(negedge clk);

        for (int t = 0; t < 2; t++)
            for (int a = 1; a < 32; a++) begin
                idle(); wb(1'(t), 5'(a), $urandom); tick();
            end

        // back-to-back, x1..x4 = 0x11..0x44
        for (int i = 1; i <= 4; i++) begin
            idle(); wb(0, 5'(i), 32'(i * 'h11)); tick();
        end
        idle(); tick();
        b0 = beats;
        exact_lat = 1;
        for (int i = 1; i <= 4; i++) begin
            idle(); offer(0, 5'(i), 5'(i + 1)); tick();
        end
        repeat (4) begin idle(); tick(); end
        exact_lat = 0;
        check("b2b_beats", 64'(beats - b0), 64'd4);

        // RAW on the read edge, in S1, and during an EX stall
        idle(); offer(0, 5, 0); wb(0, 5, 32'hA5A5); tick();
        repeat (3) begin idle(); tick(); end
        idle(); wb(0, 5, 32'h1234); tick();
        idle(); offer(0, 5, 5); tick();
        idle(); wb(0, 5, 32'hA5A5); tick();
        repeat (3) begin idle(); tick(); end
        idle(); wb(0, 5, 32'h5555); tick();
        idle(); ex_ready = 0; offer(0, 5, 0); tick();
        idle(); ex_ready = 0; tick();
        idle(); ex_ready = 0; wb(0, 5, 32'hA5A5); tick();
        idle(); ex_ready = 0; tick();
        repeat (3) begin idle(); tick(); end
        check("raw_x5", 64'(regs[0][5]), 64'hA5A5);

        // x0 and task isolation
        idle(); offer(0, 0, 5); wb(0, 0, 32'hFFFF); tick();
        idle(); wb(1, 5, 32'hFFFF); tick();
        idle(); offer(0, 5, 0); wb(1, 5, 32'hEEEE); tick();
        repeat (3) begin idle(); tick(); end

        // EX stall with S1 full
        idle(); ex_ready = 0; offer(0, 1, 2); tick();
        idle(); ex_ready = 0; offer(1, 3, 4); tick();
        for (int i = 0; i < 3; i++) begin
            idle(); ex_ready = 0; offer(0, 6, 7);
            #1 check("stall_idrdy", 64'(id_ready), 64'd0);
            tick();
        end
        repeat (4) begin idle(); tick(); end

        // AR_EN pulse while S1 holds an entry
        idle(); ex_ready = 0; offer(0, 1, 0); tick();
        idle(); ex_ready = 0; offer(0, 3, 2); tick();
        idle(); ex_ready = 0; ar_en = 1; tick();
        idle(); ar_en = 1; tick();
        idle(); #1 check("ar_hold1", 64'(ex_valid), 64'd0);
        check("ar_idrdy", 64'(id_ready), 64'd0);
        tick();
        idle(); #1 check("ar_hold2", 64'(ex_valid), 64'd0); tick();
        idle(); #1 check("ar_issue", 64'(ex_valid), 64'd1); tick();
        repeat (2) begin idle(); tick(); end

        // FLUSH task 1 in S1 while task 0 waits in S2
        b0 = beats;
        idle(); ex_ready = 0; offer(0, 2, 3); tick();
        idle(); ex_ready = 0; offer(1, 4, 5); tick();
        idle(); ex_ready = 0; flush = 1; flush_task = 1; tick();
        repeat (4) begin idle(); tick(); end
        check("flush_beats", 64'(beats - b0), 64'd1);

        // async reset with EX_VALID high
        idle(); ex_ready = 0; offer(0, 1, 2); tick();
        idle(); ex_ready = 0; tick();
        idle(); ex_ready = 0;
        #1 check("pre_rst_exv", 64'(ex_valid), 64'd1);
        rst_n = 0;
        #1 check("rst_mid_exv", 64'(ex_valid), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        b0 = beats;
        idle(); offer(1, 3, 4); tick();
        repeat (3) begin idle(); tick(); end
        check("post_rst_beat", 64'(beats - b0), 64'd1);

        // random traffic
        arc = 0;
        for (int i = 0; i < 3000; i++) begin
            idle();
            if ($urandom_range(3) != 0)
                offer(1'($urandom), 5'($urandom_range(7)),
                      5'($urandom_range(7)));
            if ($urandom_range(1) != 0)
                wb(1'($urandom), 5'($urandom_range(7)), $urandom);
            ex_ready = ($urandom_range(3) != 0);
            if (arc > 0) begin
                ar_en = 1; arc--;
            end else if ($urandom_range(31) == 0) begin
                arc = $urandom_range(1, 2);
            end
            if ($urandom_range(15) == 0) begin
                flush = 1; flush_task = 1'($urandom);
            end
            tick();
        end
        repeat (10) begin idle(); tick(); end
        check("drain", 64'(q.size()), 64'd0);
        check("drain_exv", 64'(ex_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
